// File: rtl/als_pkg.sv
// Shared definitions for the PmodALS sampling path: scheduler state codes and
// the data/counter widths seen by the SPI interface and the filter datapath.
package als_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

   localparam int ALS_DATA_W   = 8;
   localparam int SAMPLE_CNT_W = 16;

endpackage

// File: rtl/als_period_timer.sv
// Free-running sample-period counter that raises a periodic request on the
// first enabled cycle and every PERIOD_CYCLES cycles after that.
module als_period_timer #(
   parameter int PERIOD_CYCLES = 100000,
   parameter int CNT_W         = 24
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic preq
);

   localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] pcnt;

   // Holding the counter at zero while disabled makes re-enabling fire a request immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt <= '0;
      end else if (!enable) begin
         pcnt <= '0;
      end else if (pcnt == PCNT_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + CNT_W'(1);
      end
   end

   assign preq = enable && (pcnt == '0);

endmodule

// File: rtl/als_sample_scheduler.sv
// Sequences PmodALS conversions: periodic or single-shot starts, result latch,
// sample counting, a conversion watchdog and sticky error flags.
module als_sample_scheduler
   import als_pkg::*;
#(
   parameter int PERIOD_CYCLES  = 100000,
   parameter int TIMEOUT_CYCLES = 2048,
   parameter int CNT_W          = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    single_shot,
   input  logic                    clr_err,
   input  logic                    conv_valid,
   input  logic [ALS_DATA_W-1:0]   conv_data,
   output logic                    start_conv,
   output logic                    conv_abort,
   output logic                    busy,
   output logic [ALS_DATA_W-1:0]   sample_data,
   output logic                    sample_valid,
   output logic [SAMPLE_CNT_W-1:0] sample_count,
   output logic                    timeout_err,
   output logic                    overrun
);

   // One extra count of headroom so the increment on the timeout cycle never wraps.
   localparam int                TCNT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]        state;
   logic [TCNT_W-1:0] tcnt;
   logic              preq;
   logic              timeout_hit;
   logic              overrun_hit;

   als_period_timer #(
      .PERIOD_CYCLES (PERIOD_CYCLES),
      .CNT_W         (CNT_W)
   ) u_period_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .preq   (preq)
   );

   // A valid arriving on the last allowed cycle still counts as a good sample.
   assign timeout_hit = (state == ST_WAIT) && !conv_valid && (tcnt == TIMEOUT_LAST);
   assign overrun_hit = preq && (state != ST_IDLE);
   assign busy        = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         tcnt       <= '0;
         start_conv <= 1'b0;
         conv_abort <= 1'b0;
      end else begin
         start_conv <= 1'b0;
         conv_abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (preq || single_shot) begin
                  start_conv <= 1'b1;
                  tcnt       <= '0;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               tcnt <= tcnt + TCNT_W'(1);
               if (conv_valid) begin
                  state <= ST_IDLE;
               end else if (timeout_hit) begin
                  conv_abort <= 1'b1;
                  state      <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stray valids outside WAIT leave the latched sample untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_data  <= '0;
         sample_valid <= 1'b0;
         sample_count <= '0;
      end else begin
         sample_valid <= 1'b0;
         if ((state == ST_WAIT) && conv_valid) begin
            sample_data  <= conv_data;
            sample_valid <= 1'b1;
            sample_count <= sample_count + SAMPLE_CNT_W'(1);
         end
      end
   end

   // Sticky flags; a new event in the same cycle beats a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end else if (clr_err) begin
            timeout_err <= 1'b0;
         end
         if (overrun_hit) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_als_sample_scheduler.sv
// Self-checking bench for als_sample_scheduler: directed scenarios plus a randomized
// phase, all outputs compared each cycle against a conversion-level reference model.
module tb_als_sample_scheduler;

   localparam int PERIOD  = 1000;
   localparam int TIMEOUT = 900;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        single_shot;
   logic        clr_err;
   logic        conv_valid;
   logic [7:0]  conv_data;
   logic        start_conv;
   logic        conv_abort;
   logic        busy;
   logic [7:0]  sample_data;
   logic        sample_valid;
   logic [15:0] sample_count;
   logic        timeout_err;
   logic        overrun;

   always #5 clk = ~clk;

   als_sample_scheduler #(
      .PERIOD_CYCLES  (PERIOD),
      .TIMEOUT_CYCLES (TIMEOUT),
      .CNT_W          (24)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .single_shot  (single_shot),
      .clr_err      (clr_err),
      .conv_valid   (conv_valid),
      .conv_data    (conv_data),
      .start_conv   (start_conv),
      .conv_abort   (conv_abort),
      .busy         (busy),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_count (sample_count),
      .timeout_err  (timeout_err),
      .overrun      (overrun)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: a conversion is "in flight" for a number of cycles (its age);
   // it ends on a valid, or on its TIMEOUT-th cycle followed by one abort cycle.
   int          cyc      = 0;
   bit          m_conv   = 0;
   bit          m_abortc = 0;
   int          m_age    = 0;
   int          m_run    = 0;
   logic [7:0]  m_data   = '0;
   int          m_count  = 0;
   bit          m_err    = 0;
   bit          m_ovr    = 0;
   bit          m_start  = 0;
   bit          m_abort  = 0;
   bit          m_sv     = 0;

   always @(posedge clk) begin
      bit preq;
      bit idle_before;
      bit err_event;
      cyc++;
      preq      = enable && ((m_run % PERIOD) == 0);
      m_start   = 0;
      m_abort   = 0;
      m_sv      = 0;
      err_event = 0;
      if (reset) begin
         m_conv = 0; m_abortc = 0; m_age = 0; m_run = 0;
         m_data = '0; m_count = 0; m_err = 0; m_ovr = 0;
      end else begin
         idle_before = !m_conv && !m_abortc;
         if (m_abortc) begin
            m_abortc = 0;
         end else if (m_conv) begin
            if (conv_valid) begin
               m_data  = conv_data;
               m_sv    = 1;
               m_count = (m_count + 1) % 65536;
               m_conv  = 0;
            end else if (m_age == TIMEOUT - 1) begin
               err_event = 1;
               m_abort   = 1;
               m_conv    = 0;
               m_abortc  = 1;
            end
            m_age++;
         end else if (preq || single_shot) begin
            m_start = 1;
            m_conv  = 1;
            m_age   = 0;
         end
         if (err_event) m_err = 1;
         else if (clr_err) m_err = 0;
         if (preq && !idle_before) m_ovr = 1;
         else if (clr_err) m_ovr = 0;
         m_run = enable ? m_run + 1 : 0;
      end
   end

   // ALS interface BFM: answers start_conv after bfm_delay cycles (0 = never).
   int         bfm_delay   = 805;
   int         bfm_remain  = 0;
   bit         bfm_pending = 0;
   bit         stray_req   = 0;
   logic [7:0] bfm_data    = '0;

   int start_q[$];
   int sv_q[$];
   int ab_q[$];

   task automatic applyStimulus(input bit ss, input bit clr);
      @(negedge clk);
      checkOutput("outs",
                  {2'b00, start_conv, conv_abort, busy, sample_valid, timeout_err, overrun, sample_data, sample_count},
                  {2'b00, m_start, m_abort, (m_conv | m_abortc), m_sv, m_err, m_ovr, m_data, 16'(m_count)});
      if (start_conv)   start_q.push_back(cyc);
      if (sample_valid) sv_q.push_back(cyc);
      if (conv_abort)   ab_q.push_back(cyc);
      conv_valid = 1'b0;
      if (bfm_pending) begin
         bfm_remain--;
         if (bfm_remain == 0) begin
            conv_valid  = 1'b1;
            bfm_pending = 0;
         end
      end
      if (start_conv && bfm_delay >= 2) begin
         bfm_pending = 1;
         bfm_remain  = bfm_delay - 1;
      end
      if (stray_req) begin
         conv_valid = 1'b1;
         stray_req  = 0;
      end
      conv_data   = bfm_data;
      single_shot = ss;
      clr_err     = clr;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      reset = 1'b0;
      start_q.delete(); sv_q.delete(); ab_q.delete();
   endtask

   initial begin
      int t0;
      int delays[7];
      delays = '{805, 300, 899, 900, 901, 0, 50};
      reset = 1'b1; enable = 1'b0; single_shot = 1'b0; clr_err = 1'b0;
      conv_valid = 1'b0; conv_data = '0;

      repeat (3) applyStimulus(1'b0, 1'b0);
      checkOutput("reset_outs",
                  {2'b00, start_conv, conv_abort, busy, sample_valid, timeout_err, overrun, sample_data, sample_count}, 32'd0);
      reset = 1'b0;
      start_q.delete(); sv_q.delete(); ab_q.delete();

      $display("[TB] periodic sampling");
      bfm_delay = 805; bfm_data = 8'h42;
      t0 = cyc; enable = 1'b1;
      runCycles(2850);
      enable = 1'b0;
      runCycles(5);
      checkOutput("per_starts", start_q.size(), 3);
      checkOutput("per_samples", sv_q.size(), 3);
      for (int i = 0; i < 3 && i < start_q.size(); i++)
         checkOutput("per_start_cycle", start_q[i] - t0, 1 + PERIOD * i);
      for (int i = 0; i < 3 && i < sv_q.size() && i < start_q.size(); i++)
         checkOutput("per_latency", sv_q[i] - start_q[i], 805);
      checkOutput("per_count", sample_count, 3);
      checkOutput("per_flags", {timeout_err, overrun}, 0);

      $display("[TB] single shot");
      start_q.delete(); sv_q.delete();
      bfm_data = 8'hA5;
      applyStimulus(1'b1, 1'b0);
      runCycles(850);
      checkOutput("ss_starts", start_q.size(), 1);
      checkOutput("ss_pulses", sv_q.size(), 1);
      checkOutput("ss_data", sample_data, 8'hA5);
      checkOutput("ss_busy", busy, 0);
      checkOutput("ss_count", sample_count, 4);

      $display("[TB] timeout");
      pulseReset();
      bfm_delay = 0;
      t0 = cyc; enable = 1'b1;
      runCycles(950);
      checkOutput("to_aborts", ab_q.size(), 1);
      if (ab_q.size() > 0 && start_q.size() > 0)
         checkOutput("to_abort_cycle", ab_q[0] - start_q[0], TIMEOUT);
      checkOutput("to_err", timeout_err, 1);
      checkOutput("to_busy", busy, 0);
      bfm_delay = 805;
      runCycles(100);
      checkOutput("to_restart", start_q.size(), 2);
      if (start_q.size() > 1) checkOutput("to_restart_cycle", start_q[1] - t0, 1 + PERIOD);
      enable = 1'b0;
      runCycles(820);
      checkOutput("to_finish_disabled", sample_count, 1);

      $display("[TB] overrun");
      pulseReset();
      bfm_delay = 805;
      applyStimulus(1'b1, 1'b0);
      runCycles(400);
      enable = 1'b1;
      runCycles(3);
      checkOutput("ovr_set", overrun, 1);
      checkOutput("ovr_dropped", start_q.size(), 1);
      runCycles(500);
      checkOutput("ovr_sticky", overrun, 1);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("ovr_clear", overrun, 0);
      enable = 1'b0;
      runCycles(2);

      $display("[TB] valid on timeout cycle and stray valid");
      pulseReset();
      bfm_delay = 900; bfm_data = 8'h5A;
      applyStimulus(1'b1, 1'b0);
      runCycles(950);
      checkOutput("edge_samples", sv_q.size(), 1);
      if (sv_q.size() > 0 && start_q.size() > 0)
         checkOutput("edge_latency", sv_q[0] - start_q[0], TIMEOUT);
      checkOutput("edge_aborts", ab_q.size(), 0);
      checkOutput("edge_err", timeout_err, 0);
      bfm_data = 8'h3C; stray_req = 1;
      runCycles(5);
      checkOutput("stray_data", sample_data, 8'h5A);
      checkOutput("stray_count", sample_count, 1);
      checkOutput("stray_pulses", sv_q.size(), 1);

      $display("[TB] reset mid conversion");
      pulseReset();
      bfm_delay = 805; bfm_data = 8'h77;
      applyStimulus(1'b1, 1'b0);
      runCycles(400);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      reset = 1'b0;
      checkOutput("midrst_outs",
                  {2'b00, start_conv, conv_abort, busy, sample_valid, timeout_err, overrun, sample_data, sample_count}, 32'd0);
      sv_q.delete();
      runCycles(500);
      checkOutput("midrst_late_valid", sv_q.size(), 0);
      checkOutput("midrst_count", sample_count, 0);

      $display("[TB] randomized traffic");
      pulseReset();
      for (int i = 0; i < 30000; i++) begin
         if ($urandom_range(0, 1499) == 0) enable = ~enable;
         if (!bfm_pending) bfm_delay = delays[$urandom_range(0, 6)];
         if (!bfm_pending && $urandom_range(0, 499) == 0) stray_req = 1;
         bfm_data = 8'($urandom);
         reset = ($urandom_range(0, 3999) == 0);
         applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 299) == 0);
      end
      reset = 1'b0;
      runCycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
